// File: rtl/mux_8x1_rr_scheduler_if.sv
// mux_8x1_rr_scheduler_if: request/data/grant bundle between sources, consumer and scheduler
interface mux_8x1_rr_scheduler_if;
    logic [7:0] req;
    logic [7:0] d;
    logic       ack;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       valid;
    modport master (output req, d, ack, input gnt, sel, y, valid);
    modport slave (input req, d, ack, output gnt, sel, y, valid);
endinterface

// File: rtl/mux_8x1_rr_scheduler.sv
// mux_8x1_rr_scheduler: round-robin 8:1 mux with bounded hold per grant and one idle cycle between grants
module mux_8x1_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input logic clk,
    input logic rst,
    mux_8x1_rr_scheduler_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [2:0] ptr, ptr_n, idx, idx_n, cnt, cnt_n, pick;
    logic rel;
    assign bus.y = bus.d[bus.sel];
    // first requesting source at or after ptr; higher offsets are overwritten by lower ones
    always_comb begin
        pick = '0;
        for (int k = 7; k >= 0; k--)
            if (bus.req[ptr + 3'(k)]) pick = ptr + 3'(k);
    end
    // next state: grab a source from IDLE, release on withdrawal or on the last allowed transfer
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        idx_n = idx;
        cnt_n = cnt;
        rel = !bus.req[idx] || (bus.ack && cnt == 3'(MAX_HOLD - 1));
        if (state == IDLE) begin
            if (|bus.req) begin
                state_n = GRANT;
                idx_n = pick;
            end
        end else if (rel) begin
            state_n = IDLE;
            ptr_n = idx + 3'd1;
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 3'(bus.ack);
        end
    end
    // state and registered outputs; sel keeps the last granted index while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            idx <= '0;
            cnt <= '0;
            bus.gnt <= '0;
            bus.sel <= '0;
            bus.valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            idx <= idx_n;
            cnt <= cnt_n;
            bus.gnt <= state_n == GRANT ? 8'd1 << idx_n : '0;
            bus.sel <= state_n == GRANT ? idx_n : bus.sel;
            bus.valid <= state_n == GRANT;
        end
    end
endmodule

// File: tb/tb_mux_8x1_rr_scheduler.sv
// tb_mux_8x1_rr_scheduler: directed pins plus randomized run against a transaction-level model
module tb_mux_8x1_rr_scheduler;
    localparam int MAX_HOLD = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    mux_8x1_rr_scheduler_if bus();
    mux_8x1_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: who owns the mux, how many items it moved, where the next search begins
    int m_owner = -1;
    int m_count = 0;
    int m_start = 0;
    int m_sel = 0;
    int m_wait[8];
    int obs_xfers = 0;
    bit armed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.valid === 1'b1 && bus.ack) obs_xfers++;
        if (bus.gnt === 8'h00) obs_xfers = 0;
        if (rst) begin
            armed = 1;
            m_owner = -1;
            m_count = 0;
            m_start = 0;
            m_sel = 0;
            for (int i = 0; i < 8; i++) m_wait[i] = 0;
        end else if (m_owner < 0) begin
            if (bus.req != 0) begin
                for (int k = 7; k >= 0; k--)
                    if (bus.req[(m_start + k) % 8]) m_owner = (m_start + k) % 8;
                m_count = 0;
                m_sel = m_owner;
                for (int i = 0; i < 8; i++)
                    if (i == m_owner) m_wait[i] = 0;
                    else if (bus.req[i]) m_wait[i]++;
            end
        end else begin
            if (bus.ack) m_count++;
            if (!bus.req[m_owner] || m_count == MAX_HOLD) begin
                m_start = (m_owner + 1) % 8;
                m_owner = -1;
                m_count = 0;
            end
        end
        for (int i = 0; i < 8; i++) if (!bus.req[i]) m_wait[i] = 0;
    end

    always @(negedge clk) begin
        if (armed) begin
            int worst;
            worst = 0;
            for (int i = 0; i < 8; i++) if (m_wait[i] > worst) worst = m_wait[i];
            chk("gnt", bus.gnt, m_owner >= 0 ? 32'(1) << m_owner : 0);
            chk("valid", bus.valid, m_owner >= 0);
            chk("sel", bus.sel, m_sel);
            chk("y_model", bus.y, bus.d[m_sel]);
            chk("y_mux", bus.y, bus.d[bus.sel]);
            chk("onehot", $onehot0(bus.gnt), 1);
            chk("hold_limit", obs_xfers <= MAX_HOLD, 1);
            chk("fairness", worst <= 8, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_exp [10] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00};

    initial begin
        bus.req = '0;
        bus.d = '0;
        bus.ack = 1'b0;
        step();
        rst = 1'b0;
        bus.req = 8'hFF;
        bus.ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("seq_ff", bus.gnt, seq_exp[i]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 8'h08;
        bus.d = 8'h08;
        bus.ack = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("hold_gnt", bus.gnt, 8'h08);
        chk("hold_sel", bus.sel, 3);
        chk("hold_y", bus.y, 1);
        chk("hold_valid", bus.valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 8'h40;
        step();
        chk("pre_rst_gnt", bus.gnt, 8'h40);
        rst = 1'b1;
        step();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_valid", bus.valid, 0);
        rst = 1'b0;
        step();
        chk("post_rst_gnt", bus.gnt, 8'h40);
        for (int c = 0; c < 10000; c++) begin
            bus.req = bus.req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            bus.d = 8'($urandom);
            bus.ack = $urandom_range(0, 9) < 6;
            rst = $urandom_range(0, 499) == 0;
            step();
        end
        rst = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
